// File: rtl/gate_sweep_pkg.sv
// gate_sweep_pkg
// Shared definitions for the gate truth-table sweep controller.
//   state_e         : sweep FSM states
//   NAND3_TT ..     : reference truth tables for 3-input gates, bit i = output at input vector i
//   vec_count()     : number of input vectors for a given input count
package gate_sweep_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HOLD   = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_e;

    localparam logic [7:0] NAND3_TT = 8'b0111_1111;
    localparam logic [7:0] AND3_TT  = 8'b1000_0000;
    localparam logic [7:0] OR3_TT   = 8'b1111_1110;
    localparam logic [7:0] NOR3_TT  = 8'b0000_0001;

    function automatic int vec_count(input int n_in);
        return 1 << n_in;
    endfunction

endpackage

// File: rtl/gate_sweep_if.sv
// gate_sweep_if
// Bundles the sweep controller's control, stimulus and result signals.
//   start, abort   : sweep control requests
//   stim, dut_y    : vector driven onto the gate under test and its output
//   busy, done     : sweep in progress / one-cycle completion pulse
//   pass, fail_cnt, first_fail, observed : results of the current/last sweep
//   dbg_state      : controller FSM state, for observation only
// Modports: slave = the controller, master = whoever commands it and models the gate.
//
// Handshake: start is a level request sampled on every rising edge; it is
// accepted only when busy is low (IDLE or the DONE cycle) and abort is low.
// While busy is high start is ignored. abort is sampled on every edge and
// cancels a sweep in progress; it takes priority over a simultaneous start.
interface gate_sweep_if #(
    parameter int N_IN = 3
);
    import gate_sweep_pkg::*;

    localparam int V = 1 << N_IN;

    logic            start;
    logic            abort;
    logic [N_IN-1:0] stim;
    logic            dut_y;
    logic            busy;
    logic            done;
    logic            pass;
    logic [N_IN:0]   fail_cnt;
    logic [N_IN-1:0] first_fail;
    logic [V-1:0]    observed;
    state_e          dbg_state;

    modport slave (
        input  start, abort, dut_y,
        output stim, busy, done, pass, fail_cnt, first_fail, observed, dbg_state
    );

    modport master (
        output start, abort, dut_y,
        input  stim, busy, done, pass, fail_cnt, first_fail, observed, dbg_state
    );

endinterface

// File: rtl/gate_sweep_timer.sv
// gate_sweep_timer
// Hold counter that measures how long a vector has been applied.
//   clk, rst : clock, asynchronous active-high reset
//   clr_i    : restart the count at zero (takes priority over en_i)
//   en_i     : count one cycle
//   tc_o     : high while the count equals SETTLE-1 (last hold cycle)
module gate_sweep_timer #(
    parameter int SETTLE = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    output logic tc_o
);

    // One spare code so the increment on the terminal cycle cannot alias to zero.
    localparam int CW = $clog2(SETTLE + 1);
    localparam logic [CW-1:0] TC_VAL  = CW'(SETTLE - 1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + CNT_ONE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc_o = (cnt_q == TC_VAL);

endmodule

// File: rtl/gate_sweep_ctrl.sv
// gate_sweep_ctrl
// Exhaustive truth-table sequencer for a small combinational gate. Drives every
// input vector in ascending order, holds each for SETTLE cycles, samples the gate
// output in a following SAMPLE cycle and compares it against EXPECT.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : gate_sweep_if.slave (start/abort in, stim out, dut_y in, results out)
// Parameters: N_IN inputs (V = 2**N_IN vectors), SETTLE hold cycles, EXPECT table.
// Optional feature macro GATE_SWEEP_STOP_ON_FAIL_EN: end the sweep at the first
// mismatching vector instead of sweeping all V vectors.
module gate_sweep_ctrl
    import gate_sweep_pkg::*;
#(
    parameter int                    N_IN   = 3,
    parameter int                    SETTLE = 2,
    parameter logic [(1<<N_IN)-1:0]  EXPECT = NAND3_TT
) (
    input  logic         clk,
    input  logic         rst,
    gate_sweep_if.slave  bus
);

    localparam int V = 1 << N_IN;
    localparam logic [N_IN-1:0] VEC_ONE  = N_IN'(1);
    localparam logic [N_IN:0]   FAIL_ONE = (N_IN + 1)'(1);

    state_e          state_q, state_d;
    logic [N_IN-1:0] vec_q, vec_d;
    logic [N_IN:0]   fail_q, fail_d;
    logic [N_IN-1:0] ff_q, ff_d;
    logic [V-1:0]    obs_q, obs_d;
    logic            pass_q, pass_d;

    logic tmr_clr;
    logic tmr_en;
    logic tmr_tc;
    logic mismatch;
    logic last_vec;
    logic sweep_end;
    logic busy;

    gate_sweep_timer #(
        .SETTLE (SETTLE)
    ) u_timer (
        .clk   (clk),
        .rst   (rst),
        .clr_i (tmr_clr),
        .en_i  (tmr_en),
        .tc_o  (tmr_tc)
    );

    assign mismatch = bus.dut_y ^ EXPECT[vec_q];
    assign last_vec = &vec_q;

`ifdef GATE_SWEEP_STOP_ON_FAIL_EN
    assign sweep_end = last_vec | mismatch;
`else
    assign sweep_end = last_vec;
`endif

    always_comb begin
        state_d = state_q;
        vec_d   = vec_q;
        fail_d  = fail_q;
        ff_d    = ff_q;
        obs_d   = obs_q;
        pass_d  = pass_q;
        tmr_clr = 1'b0;
        tmr_en  = 1'b0;

        case (state_q)
            // DONE behaves like IDLE for start so back-to-back sweeps lose no cycle.
            IDLE, DONE: begin
                state_d = IDLE;
                if (bus.start && !bus.abort) begin
                    state_d = HOLD;
                    vec_d   = '0;
                    fail_d  = '0;
                    ff_d    = '0;
                    obs_d   = '0;
                    pass_d  = 1'b0;
                    tmr_clr = 1'b1;
                end
            end

            HOLD: begin
                tmr_en = 1'b1;
                if (bus.abort) begin
                    state_d = IDLE;
                end else if (tmr_tc) begin
                    state_d = SAMPLE;
                end
            end

            SAMPLE: begin
                if (bus.abort) begin
                    state_d = IDLE;
                end else begin
                    obs_d[vec_q] = bus.dut_y;
                    if (mismatch) begin
                        fail_d = fail_q + FAIL_ONE;
                        if (fail_q == '0) begin
                            ff_d = vec_q;
                        end
                    end
                    if (sweep_end) begin
                        state_d = DONE;
                        // Uses this cycle's updated count so the final vector counts.
                        pass_d  = (fail_d == '0);
                    end else begin
                        state_d = HOLD;
                        vec_d   = vec_q + VEC_ONE;
                        tmr_clr = 1'b1;
                    end
                end
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            vec_q   <= '0;
            fail_q  <= '0;
            ff_q    <= '0;
            obs_q   <= '0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            fail_q  <= fail_d;
            ff_q    <= ff_d;
            obs_q   <= obs_d;
            pass_q  <= pass_d;
        end
    end

    // Outputs decode directly from registers so an asynchronous reset clears them at once.
    assign busy           = (state_q == HOLD) || (state_q == SAMPLE);
    assign bus.busy       = busy;
    assign bus.stim       = busy ? vec_q : '0;
    assign bus.done       = (state_q == DONE);
    assign bus.pass       = pass_q;
    assign bus.fail_cnt   = fail_q;
    assign bus.first_fail = ff_q;
    assign bus.observed   = obs_q;
    assign bus.dbg_state  = state_q;

endmodule

// File: tb/tb_gate_sweep_ctrl.sv
// tb_gate_sweep_ctrl
// Two controller instances: unit 0 with defaults (3 inputs, SETTLE=2, NAND3 table)
// and unit 1 with 2 inputs, SETTLE=1, NAND2 table. The gate under test is a
// truth table held by the bench. Expected sweep results are pushed when a sweep
// is launched; a negedge monitor tracks the sweep timeline and pops/compares.
module tb_gate_sweep_ctrl;
    import gate_sweep_pkg::*;

    typedef struct packed {
        logic       unit;
        logic [7:0] obs;
        logic [3:0] fcnt;
        logic [2:0] ff;
        logic       pass;
        logic [7:0] len;
    } exp_t;

    localparam int EW = $bits(exp_t);

    logic clk;
    logic rst;
    logic [1:0] start_v;
    logic [1:0] abort_v;
    logic [7:0] tt_a [2];

    logic [1:0] busy_v, done_v, pass_v;
    logic [2:0] stim_a [2];
    logic [3:0] fcnt_a [2];
    logic [2:0] ff_a   [2];
    logic [7:0] obs_a  [2];

    int checks;
    int failures;
    logic [EW-1:0] exp_q[$];

    gate_sweep_if #(.N_IN(3)) bus0 ();
    gate_sweep_if #(.N_IN(2)) bus1 ();

    gate_sweep_ctrl u_dut0 (
        .clk (clk),
        .rst (rst),
        .bus (bus0)
    );

    gate_sweep_ctrl #(
        .N_IN   (2),
        .SETTLE (1),
        .EXPECT (4'b0111)
    ) u_dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    assign bus0.start = start_v[0];
    assign bus0.abort = abort_v[0];
    assign bus0.dut_y = tt_a[0][bus0.stim];
    assign bus1.start = start_v[1];
    assign bus1.abort = abort_v[1];
    assign bus1.dut_y = tt_a[1][bus1.stim];

    assign busy_v    = {bus1.busy, bus0.busy};
    assign done_v    = {bus1.done, bus0.done};
    assign pass_v    = {bus1.pass, bus0.pass};
    assign stim_a[0] = bus0.stim;
    assign stim_a[1] = {1'b0, bus1.stim};
    assign fcnt_a[0] = bus0.fail_cnt;
    assign fcnt_a[1] = {1'b0, bus1.fail_cnt};
    assign ff_a[0]   = bus0.first_fail;
    assign ff_a[1]   = {1'b0, bus1.first_fail};
    assign obs_a[0]  = bus0.observed;
    assign obs_a[1]  = {4'b0, bus1.observed};

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    // ---------------- reference model helpers ----------------
    function automatic int settle(input int u);
        return (u == 0) ? 2 : 1;
    endfunction

    function automatic int nvec(input int u);
        return (u == 0) ? 8 : 4;
    endfunction

    function automatic logic [7:0] expv(input int u);
        return (u == 0) ? NAND3_TT : 8'h07;
    endfunction

    // Results after the first nsamp vectors of a sweep of gate table tt.
    function automatic exp_t calc(input int u, input logic [7:0] tt, input int nsamp);
        exp_t e;
        int   s;
        int   nv;
        logic [7:0] ex;
        bit   stop;
        s    = settle(u);
        nv   = nvec(u);
        ex   = expv(u);
        stop = 1'b0;
        e       = '0;
        e.unit  = u[0];
        e.len   = 8'(nv * (s + 1));
        for (int v = 0; v < nsamp; v++) begin
            if (!stop) begin
                e.obs[v[2:0]] = tt[v[2:0]];
                if (tt[v[2:0]] != ex[v[2:0]]) begin
                    if (e.fcnt == 4'd0) e.ff = v[2:0];
                    e.fcnt = e.fcnt + 4'd1;
`ifdef GATE_SWEEP_STOP_ON_FAIL_EN
                    stop  = 1'b1;
                    e.len = 8'((v + 1) * (s + 1));
`endif
                end
            end
        end
        e.pass = (e.fcnt == 4'd0) && (nsamp == nv);
        return e;
    endfunction

    task automatic chk(input string nm, input int u, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            if (failures <= 40)
                $display("FAIL %s unit=%0d got=%0h exp=%0h at %0t", nm, u, act, exp, $time);
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    bit   act_m  [2];
    bit   dn_m   [2];
    bit   hv_m   [2];
    int   t_m    [2];
    exp_t cur_m  [2];
    exp_t held_m [2];

    always @(negedge clk) begin
        for (int u = 0; u < 2; u++) begin
            int s;
            s = settle(u);
            if (rst) begin
                act_m[u]  = 1'b0;
                dn_m[u]   = 1'b0;
                hv_m[u]   = 1'b1;
                held_m[u] = '0;
            end
            chk("busy", u, 32'(busy_v[u]), 32'(act_m[u]));
            chk("stim", u, 32'(stim_a[u]), act_m[u] ? 32'(t_m[u] / (s + 1)) : 32'd0);
            chk("done", u, 32'(done_v[u]), 32'(dn_m[u]));
            if (!act_m[u] && hv_m[u]) begin
                chk("pass",       u, 32'(pass_v[u]), 32'(held_m[u].pass));
                chk("fail_cnt",   u, 32'(fcnt_a[u]), 32'(held_m[u].fcnt));
                chk("first_fail", u, 32'(ff_a[u]),   32'(held_m[u].ff));
                chk("observed",   u, 32'(obs_a[u]),  32'(held_m[u].obs));
            end
            // Advance the model with the inputs the next rising edge will sample.
            if (rst) begin
                t_m[u] = 0;
            end else if (act_m[u]) begin
                if (abort_v[u]) begin
                    act_m[u]  = 1'b0;
                    held_m[u] = calc(u, tt_a[u], t_m[u] / (s + 1));
                    hv_m[u]   = 1'b1;
                end else if (t_m[u] == int'(cur_m[u].len) - 1) begin
                    act_m[u]  = 1'b0;
                    dn_m[u]   = 1'b1;
                    held_m[u] = cur_m[u];
                    hv_m[u]   = 1'b1;
                end else begin
                    t_m[u]++;
                end
            end else begin
                dn_m[u] = 1'b0;
                if (start_v[u] && !abort_v[u]) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL scoreboard_empty unit=%0d got=start exp=queued_sweep at %0t", u, $time);
                    end else begin
                        cur_m[u] = exp_t'(exp_q.pop_front());
                        act_m[u] = 1'b1;
                        t_m[u]   = 0;
                        hv_m[u]  = 1'b0;
                    end
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    // All drivers change inputs 2 time units after a rising edge.
    task automatic launch(input int u, input logic [7:0] tt);
        tt_a[u] = tt;
        exp_q.push_back(calc(u, tt, nvec(u)));
        @(posedge clk); #2;
        start_v[u] = 1'b1;
        @(posedge clk); #2;
        start_v[u] = 1'b0;
    endtask

    task automatic run_sweep(input int u, input logic [7:0] tt);
        exp_t e;
        e = calc(u, tt, nvec(u));
        launch(u, tt);
        repeat (int'(e.len) + 1) @(posedge clk);
        #2;
    endtask

    task automatic abort_sweep(input int u, input logic [7:0] tt, input int vec, input int h,
                               input bit with_start);
        int s;
        s = settle(u);
        launch(u, tt);
        repeat (vec * (s + 1) + h) @(posedge clk);
        #2;
        abort_v[u] = 1'b1;
        if (with_start) start_v[u] = 1'b1;
        @(posedge clk); #2;
        abort_v[u] = 1'b0;
        start_v[u] = 1'b0;
        repeat (3) @(posedge clk);
        #2;
    endtask

    task automatic held_start(input int u, input logic [7:0] tt);
        exp_t e;
        e = calc(u, tt, nvec(u));
        tt_a[u] = tt;
        exp_q.push_back(e);
        exp_q.push_back(e);
        @(posedge clk); #2;
        start_v[u] = 1'b1;
        repeat (int'(e.len) + 2) @(posedge clk);
        #2;
        start_v[u] = 1'b0;
        repeat (int'(e.len) + 1) @(posedge clk);
        #2;
    endtask

    task automatic reset_mid_sweep(input logic [7:0] tt);
        launch(0, tt);
        repeat (16) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("rst_busy",       0, 32'(bus0.busy),       32'd0);
        chk("rst_stim",       0, 32'(bus0.stim),       32'd0);
        chk("rst_done",       0, 32'(bus0.done),       32'd0);
        chk("rst_pass",       0, 32'(bus0.pass),       32'd0);
        chk("rst_fail_cnt",   0, 32'(bus0.fail_cnt),   32'd0);
        chk("rst_first_fail", 0, 32'(bus0.first_fail), 32'd0);
        chk("rst_observed",   0, 32'(bus0.observed),   32'd0);
        @(posedge clk); #3;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #2;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        start_v  = '0;
        abort_v  = '0;
        tt_a[0]  = '0;
        tt_a[1]  = '0;
        #12;
        chk("reset_busy",     0, 32'(bus0.busy),     32'd0);
        chk("reset_observed", 0, 32'(bus0.observed), 32'd0);
        chk("reset_fail_cnt", 1, 32'(bus1.fail_cnt), 32'd0);
        #11;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #2;

        run_sweep(0, NAND3_TT);
        run_sweep(0, AND3_TT);
        run_sweep(0, 8'hFF);
        run_sweep(0, OR3_TT);
        abort_sweep(0, NAND3_TT, 3, 0, 1'b0);
        run_sweep(0, NAND3_TT);
        abort_sweep(0, AND3_TT, 5, 1, 1'b1);
        reset_mid_sweep(8'hA5);
        held_start(0, NAND3_TT);
        run_sweep(1, 8'h07);
        run_sweep(1, 8'h0F);
        held_start(1, 8'h05);

        for (int i = 0; i < 20; i++) begin
            int u;
            int s;
            logic [7:0] tt;
            exp_t e;
            u  = int'($urandom_range(0, 1));
            s  = settle(u);
            tt = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 2) == 0) tt = expv(u);
            if (u == 1) tt[7:4] = 4'h0;
            if ($urandom_range(0, 3) == 0) begin
                e = calc(u, tt, nvec(u));
                abort_sweep(u, tt, int'($urandom_range(0, int'(e.len) / (s + 1) - 1)),
                            int'($urandom_range(0, s - 1)), 1'($urandom_range(0, 1)));
            end else begin
                run_sweep(u, tt);
            end
        end

        repeat (3) @(posedge clk);
        #2;
        chk("exp_q_drained", 0, 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
